axi_boot_loader: RTL and testbench

AXI4 read initiator that copies a block of 32-bit words from an AXI slave into a local single-port SRAM write port. It is the master-side counterpart of the boot ROM slave on the NoC tile. At boot, or on request, it fetches `len_words_i` consecutive words starting at `src_addr_i` and writes them to instruction/data SRAM index 0 upward. It issues single-beat reads with one transaction outstanding.

---
 rtl/axi_boot_loader.sv | 165 ++++++++++++++++
 tb/tb_axi_boot_loader.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_boot_loader.sv
// AXI4 single-beat read initiator: copies a block of 32-bit words from an AXI
// slave into a local SRAM write port, starting at SRAM index 0.

package ravenoc_pkg;
  localparam int AXI_ID_WIDTH = 4;

  typedef struct packed {
    logic [AXI_ID_WIDTH-1:0] awid;
    logic [31:0]             awaddr;
    logic [7:0]              awlen;
    logic [2:0]              awsize;
    logic [1:0]              awburst;
    logic                    awlock;
    logic [3:0]              awcache;
    logic [2:0]              awprot;
    logic [3:0]              awqos;
    logic [3:0]              awregion;
    logic                    awvalid;
    logic [31:0]             wdata;
    logic [3:0]              wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    bready;
    logic [AXI_ID_WIDTH-1:0] arid;
    logic [31:0]             araddr;
    logic [7:0]              arlen;
    logic [2:0]              arsize;
    logic [1:0]              arburst;
    logic                    arlock;
    logic [3:0]              arcache;
    logic [2:0]              arprot;
    logic [3:0]              arqos;
    logic [3:0]              arregion;
    logic                    arvalid;
    logic                    rready;
  } s_axi_mosi_t;

  typedef struct packed {
    logic                    awready;
    logic                    wready;
    logic [AXI_ID_WIDTH-1:0] bid;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    arready;
    logic [AXI_ID_WIDTH-1:0] rid;
    logic [31:0]             rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
  } s_axi_miso_t;
endpackage

module axi_boot_loader
  import ravenoc_pkg::*;
#(
  parameter int LEN_WIDTH      = 16,
  parameter int MEM_ADDR_WIDTH = 14
) (
  input  logic                      clk,
  input  logic                      arst,
  input  logic                      start_i,
  input  logic [31:0]               src_addr_i,
  input  logic [LEN_WIDTH-1:0]      len_words_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]               mem_wdata_o,
  output s_axi_mosi_t               axi_mosi,
  input  s_axi_miso_t               axi_miso
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_R
  } state_t;

  state_t                    state, state_nxt;
  logic [31:0]               cur_addr;
  logic [LEN_WIDTH-1:0]      remaining;
  logic [MEM_ADDR_WIDTH-1:0] mem_idx;

  logic start_ok, start_zero, ar_hs, r_hs, r_err, last_beat;
  logic unused_sigs;

  assign unused_sigs = ^{src_addr_i[1:0], axi_miso.awready, axi_miso.wready,
                         axi_miso.bid, axi_miso.bresp, axi_miso.bvalid,
                         axi_miso.rid, axi_miso.rlast};

  always_comb begin
    start_ok   = (state == ST_IDLE) && start_i && (len_words_i != '0);
    start_zero = (state == ST_IDLE) && start_i && (len_words_i == '0);
    ar_hs      = (state == ST_AR) && axi_miso.arready;
    r_hs       = (state == ST_R) && axi_miso.rvalid;
    r_err      = r_hs && (axi_miso.rresp != 2'b00);
    last_beat  = (remaining == LEN_WIDTH'(1));
    state_nxt  = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_AR;
      ST_AR:   if (ar_hs) state_nxt = ST_R;
      ST_R:    if (r_hs) state_nxt = (r_err || last_beat) ? ST_IDLE : ST_AR;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // AR sideband is only driven while arvalid is up so the bus reads all-zero
  // out of reset and between requests.
  always_comb begin
    axi_mosi        = '0;
    axi_mosi.rready = (state == ST_R);
    if (state == ST_AR) begin
      axi_mosi.arvalid = 1'b1;
      axi_mosi.araddr  = cur_addr;
      axi_mosi.arsize  = 3'd2;
      axi_mosi.arburst = 2'd1;
    end
  end

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cur_addr    <= '0;
      remaining   <= '0;
      mem_idx     <= '0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      done_o   <= 1'b0;
      mem_we_o <= 1'b0;
      if (start_ok || start_zero) err_o <= 1'b0;
      if (start_zero) done_o <= 1'b1;
      if (start_ok) begin
        cur_addr  <= {src_addr_i[31:2], 2'b00};
        remaining <= len_words_i;
        mem_idx   <= '0;
      end
      if (r_hs) begin
        if (r_err) begin
          err_o  <= 1'b1;
          done_o <= 1'b1;
        end else begin
          mem_we_o    <= 1'b1;
          mem_wdata_o <= axi_miso.rdata;
          mem_addr_o  <= mem_idx;
          remaining   <= remaining - LEN_WIDTH'(1);
          mem_idx     <= mem_idx + MEM_ADDR_WIDTH'(1);
          cur_addr    <= cur_addr + 32'd4;
          if (last_beat) done_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axi_boot_loader.sv
// Bench for axi_boot_loader: stalling AXI ROM slave, queue scoreboard fed by a
// transfer-level reference model, negedge monitor.

module tb_axi_boot_loader;
  import ravenoc_pkg::*;

  localparam int LW = 16;
  localparam int MW = 14;

  logic          clk = 1'b0;
  logic          arst;
  logic          start_i;
  logic [31:0]   src_addr_i;
  logic [LW-1:0] len_words_i;
  logic          busy_o, done_o, err_o, mem_we_o;
  logic [MW-1:0] mem_addr_o;
  logic [31:0]   mem_wdata_o;
  s_axi_mosi_t   axi_mosi;
  s_axi_miso_t   axi_miso;

  axi_boot_loader #(.LEN_WIDTH(LW), .MEM_ADDR_WIDTH(MW)) dut (
    .clk(clk), .arst(arst), .start_i(start_i), .src_addr_i(src_addr_i),
    .len_words_i(len_words_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .axi_mosi(axi_mosi), .axi_miso(axi_miso)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0]    exp_ar[$];
  logic [MW+31:0] exp_wr[$];
  logic           exp_done[$];

  bit          stall_en = 1'b0;
  int          err_beat = -1;
  int          s_beat = 0;
  int          s_st = 0;
  int          ar_stall, r_stall;
  logic [31:0] s_addr, hold_addr;
  bit          hold_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      32'hC:   return 32'h44;
      default: return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  function automatic int pick_stall();
    return stall_en ? int'($urandom_range(0, 5)) : 0;
  endfunction

  // Reference: a copy is the list of word addresses base+4i; an error on beat
  // err_at truncates the copy after that beat's AR, with no write for it.
  function automatic void model_push(input logic [31:0] src, input int len, input int err_at);
    logic [31:0] base, a;
    bit aborted;
    int n_ar;
    base    = src & 32'hFFFF_FFFC;
    aborted = (err_at >= 0) && (err_at < len);
    n_ar    = aborted ? err_at + 1 : len;
    for (int i = 0; i < n_ar; i++) begin
      a = base + 32'(i) * 32'd4;
      exp_ar.push_back(a);
      if (!(aborted && i == err_at)) exp_wr.push_back({MW'(i), rom(a)});
    end
    exp_done.push_back(aborted);
  endfunction

  // AXI ROM slave; s_st: 0 wait AR, 1 AR accepted, 3 R stall, 2 R beat shown
  initial begin
    axi_miso = '0;
    forever begin
      @(posedge clk); #1;
      if (arst) begin
        axi_miso   = '0;
        s_st       = 0;
        hold_valid = 1'b0;
        continue;
      end
      case (s_st)
        2: begin
          axi_miso.rvalid = 1'b0;
          axi_miso.rresp  = 2'd0;
          s_beat++;
          s_st = 0;
        end
        1: begin
          axi_miso.arready = 1'b0;
          r_stall = pick_stall();
          s_st = 3;
        end
        default: ;
      endcase
      if (s_st == 3) begin
        if (r_stall == 0) begin
          axi_miso.rvalid = 1'b1;
          axi_miso.rdata  = rom(s_addr);
          axi_miso.rresp  = (s_beat == err_beat) ? 2'd2 : 2'd0;
          axi_miso.rlast  = 1'b1;
          s_st = 2;
        end else r_stall--;
      end else if (s_st == 0 && axi_mosi.arvalid) begin
        if (!hold_valid) begin
          hold_addr  = axi_mosi.araddr;
          hold_valid = 1'b1;
          ar_stall   = pick_stall();
        end else check("araddr_stable", axi_mosi.araddr, hold_addr);
        if (ar_stall == 0) begin
          axi_miso.arready = 1'b1;
          s_addr     = axi_mosi.araddr;
          hold_valid = 1'b0;
          s_st = 1;
        end else ar_stall--;
      end
    end
  end

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!arst) begin
        if (axi_mosi.arvalid && axi_miso.arready) begin
          check("ar_expected", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) check("araddr", axi_mosi.araddr, exp_ar.pop_front());
          check("ar_fields", {axi_mosi.arid, axi_mosi.arlen, axi_mosi.arsize, axi_mosi.arburst},
                {4'd0, 8'd0, 3'd2, 2'd1});
        end
        if (mem_we_o) begin
          check("wr_expected", exp_wr.size() != 0, 1);
          if (exp_wr.size() != 0) check("mem_write", {mem_addr_o, mem_wdata_o}, exp_wr.pop_front());
        end
        if (done_o) begin
          check("done_expected", exp_done.size() != 0, 1);
          if (exp_done.size() != 0) check("done_err", err_o, exp_done.pop_front());
          check("busy_at_done", busy_o, 0);
        end
        if (axi_mosi.awvalid || axi_mosi.wvalid || axi_mosi.bready)
          check("aw_w_b_idle", {axi_mosi.awvalid, axi_mosi.wvalid, axi_mosi.bready}, 3'b0);
      end
    end
  end

  task automatic clear_queues();
    exp_ar.delete();
    exp_wr.delete();
    exp_done.delete();
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    arst = 1'b1;
    repeat (2) @(posedge clk);
    clear_queues();
    #3 arst = 1'b0;
  endtask

  task automatic run_xfer(input logic [31:0] src, input int len, input int err_at,
                          input bit stall, input bit poke);
    int k;
    bit got;
    int exp_lat;
    bit aborted;
    aborted = (err_at >= 0) && (err_at < len);
    exp_lat = aborted ? 2 * err_at + 3 : 2 * len + 1;
    model_push(src, len, err_at);
    stall_en = stall;
    err_beat = err_at;
    s_beat   = 0;
    @(posedge clk); #1;
    start_i     = 1'b1;
    src_addr_i  = src;
    len_words_i = LW'(len);
    @(posedge clk); #1;
    start_i     = 1'b0;
    src_addr_i  = $urandom;
    len_words_i = LW'($urandom);
    check("busy_after_start", busy_o, (len != 0));
    check("err_clear_on_start", err_o, 0);
    k   = 0;
    got = 1'b0;
    while (!got && k < 4000) begin
      @(negedge clk);
      k++;
      if (done_o) got = 1'b1;
      else if (poke) begin
        if (k == 3) begin
          start_i     = 1'b1;
          len_words_i = LW'(5);
          src_addr_i  = 32'h0000_9000;
        end else start_i = 1'b0;
      end
    end
    start_i = 1'b0;
    check("done_seen", got, 1);
    if (!got) do_reset();
    else if (!stall) check("done_latency", k, exp_lat);
    repeat (2) @(negedge clk);
    check("ar_drained", exp_ar.size(), 0);
    check("wr_drained", exp_wr.size(), 0);
    check("done_drained", exp_done.size(), 0);
    clear_queues();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arst        = 1'b1;
    start_i     = 1'b0;
    src_addr_i  = '0;
    len_words_i = '0;
    repeat (2) @(posedge clk); #1;
    check("rst_ctrl", {busy_o, done_o, err_o, mem_we_o}, 4'b0);
    check("rst_mem", {mem_addr_o, mem_wdata_o}, '0);
    check("rst_axi", |axi_mosi, 0);
    #2 arst = 1'b0;

    run_xfer(32'h0000_0000, 4, -1, 1'b0, 1'b0);
    run_xfer(32'h0000_0103, 2, -1, 1'b0, 1'b0);
    run_xfer(32'h0001_0000, 64, -1, 1'b1, 1'b0);
    run_xfer(32'h0000_2000, 8, 2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("err_sticky", err_o, 1);
    run_xfer(32'h0000_3000, 1, -1, 1'b0, 1'b0);
    run_xfer(32'h0000_0500, 0, -1, 1'b0, 1'b0);
    run_xfer(32'h0000_0600, 8, -1, 1'b0, 1'b1);
    run_xfer(32'hFFFF_FFF8, 3, -1, 1'b0, 1'b0);

    // reset in the middle of an 8-word copy
    model_push(32'h0000_4000, 8, -1);
    stall_en = 1'b0;
    err_beat = -1;
    s_beat   = 0;
    @(posedge clk); #1;
    start_i     = 1'b1;
    src_addr_i  = 32'h0000_4000;
    len_words_i = LW'(8);
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (4) @(posedge clk);
    #3 arst = 1'b1;
    #1;
    check("rst_mid_ctrl", {busy_o, done_o, err_o, mem_we_o}, 4'b0);
    check("rst_mid_mem", {mem_addr_o, mem_wdata_o}, '0);
    check("rst_mid_axi", |axi_mosi, 0);
    repeat (2) @(posedge clk);
    clear_queues();
    #3 arst = 1'b0;
    run_xfer(32'h0000_0000, 4, -1, 1'b0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      logic [31:0] src;
      int len;
      int ea;
      src = $urandom;
      len = int'($urandom_range(1, 12));
      ea  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      run_xfer(src, len, ea, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
